// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master round-robin arbiter for one Avalon I/O slave port
//
// Purpose:
//   Shares one Avalon I/O slave (16-bit port address, 32-bit data, byteenable)
//   between the CPU I/O master (m0) and a secondary master (m1, e.g. DMA or
//   debug). Only one transaction is in flight; the grant is held from command
//   issue until write acceptance or read data return. A read that gets no
//   s_readdatavalid within TIMEOUT cycles completes with 32'hFFFFFFFF so a
//   silent device cannot hang the CPU.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_address/m1_address      master port address (dword aligned)
//   m0_byteenable/m1_*         master byte lanes
//   m0_read/m0_write, m1_*     master command strobes
//   m0_writedata/m1_*          master write data
//   m0_waitrequest/m1_*        master stall (command not accepted)
//   m0_readdata/m1_*           registered read data, holds last value
//   m0_readdatavalid/m1_*      one-cycle read data strobe
//   s_address..s_writedata     slave command, muxed from the granted master
//   s_waitrequest              slave stall
//   s_readdata/s_readdatavalid slave read response
module io_bus_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic [15:0] m0_address,
   input  logic [3:0]  m0_byteenable,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,

   input  logic [15:0] m1_address,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,

   output logic [15:0] s_address,
   output logic [3:0]  s_byteenable,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   input  logic        s_readdatavalid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TCNT_ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic             grant;        // 0 = m0, 1 = m1
   logic             last_grant;
   logic [CNT_W-1:0] tcnt;

   logic             req0;
   logic             req1;
   logic             winner;
   logic             mg_read;
   logic             mg_write;
   logic             timeout_hit;
   logic             resp_done;
   logic [31:0]      resp_data;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // On a tie the master that did not win last time gets the bus.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
         winner = ~last_grant;
      end else begin
         winner = req1;
      end
   end

   assign mg_read      = grant ? m1_read       : m0_read;
   assign mg_write     = grant ? m1_write      : m0_write;
   assign s_address    = grant ? m1_address    : m0_address;
   assign s_byteenable = grant ? m1_byteenable : m0_byteenable;
   assign s_writedata  = grant ? m1_writedata  : m0_writedata;

   assign timeout_hit = (tcnt == TCNT_LAST);
   assign resp_done   = s_readdatavalid | timeout_hit;
   // Real slave data beats the synthetic response when both land together.
   assign resp_data   = s_readdatavalid ? s_readdata : 32'hFFFF_FFFF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = CMD;
            end
         end
         CMD: begin
            // A write wins if a master raises read and write together.
            s_write = mg_write;
            s_read  = mg_read & ~mg_write;
            if (grant) begin
               m1_waitrequest = s_waitrequest;
            end else begin
               m0_waitrequest = s_waitrequest;
            end
            if (!(mg_read || mg_write)) begin
               // Granted master withdrew its command: release the bus.
               state_nxt = IDLE;
            end else if (!s_waitrequest) begin
               state_nxt = mg_write ? IDLE : RESP;
            end
         end
         RESP: begin
            if (resp_done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant            <= 1'b0;
         last_grant       <= 1'b1;
         tcnt             <= '0;
         m0_readdata      <= '0;
         m1_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
      end else begin
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant      <= winner;
                  last_grant <= winner;
               end
            end
            CMD: begin
               if (mg_read && !mg_write && !s_waitrequest) begin
                  tcnt <= '0;
               end
            end
            RESP: begin
               if (resp_done) begin
                  if (grant) begin
                     m1_readdata      <= resp_data;
                     m1_readdatavalid <= 1'b1;
                  end else begin
                     m0_readdata      <= resp_data;
                     m0_readdatavalid <= 1'b1;
                  end
               end else begin
                  tcnt <= tcnt + TCNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] m0_address;
   logic [3:0]  m0_byteenable;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;
   logic [15:0] m1_address;
   logic [3:0]  m1_byteenable;
   logic        m1_read;
   logic        m1_write;
   logic [31:0] m1_writedata;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;
   logic [15:0] s_address;
   logic [3:0]  s_byteenable;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_bus_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_byteenable     (s_byteenable),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m0_address = 16'h0060; m0_byteenable = 4'b0001; m0_writedata = 32'h0000_00AA;
      m0_read = 1'b0; m0_write = 1'b1;
      m1_address = 16'h0000; m1_byteenable = 4'h0; m1_writedata = 32'h0;
      m1_read = 1'b0; m1_write = 1'b0;
      s_waitrequest = 1'b0; s_readdata = 32'h0; s_readdatavalid = 1'b0;
      tick(); tick();
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin
         errors++;
         $display("FAIL reset_strobes got %b expected 0011", {s_read, s_write, m0_waitrequest, m1_waitrequest});
      end
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata} !== 66'd0) begin
         errors++;
         $display("FAIL reset_readdata got %b %b %h %h expected zeros", m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({s_write, s_read, m0_waitrequest, m1_waitrequest} !== 4'b1001) begin
         errors++;
         $display("FAIL first_write_cmd got %b expected 1001", {s_write, s_read, m0_waitrequest, m1_waitrequest});
      end
      checks++;
      if ({s_address, s_byteenable, s_writedata} !== {16'h0060, 4'b0001, 32'h0000_00AA}) begin
         errors++;
         $display("FAIL first_write_fields got %h %b %h expected 0060 0001 000000aa", s_address, s_byteenable, s_writedata);
      end
      tick();
      m0_write = 1'b0;
      checks++;
      if ({s_write, m1_waitrequest} !== 2'b01) begin
         errors++;
         $display("FAIL first_write_done got %b expected 01", {s_write, m1_waitrequest});
      end
   endtask

   task automatic test_m1_read();
      logic early;
      early = 1'b0;
      m1_address = 16'h0388; m1_byteenable = 4'hF; m1_read = 1'b1;
      tick();
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, s_address, s_byteenable} !== {4'b1010, 16'h0388, 4'hF}) begin
         errors++;
         $display("FAIL m1_read_cmd got %b %h %b expected 1010 0388 1111", {s_read, s_write, m0_waitrequest, m1_waitrequest}, s_address, s_byteenable);
      end
      tick();
      m1_read = 1'b0;
      checks++;
      if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
         errors++;
         $display("FAIL m1_read_resp_idle got %b expected 011", {s_read, m0_waitrequest, m1_waitrequest});
      end
      early = early | m0_readdatavalid | m1_readdatavalid;
      tick();
      early = early | m0_readdatavalid | m1_readdatavalid;
      tick();
      s_readdatavalid = 1'b1; s_readdata = 32'h1234_5678;
      early = early | m0_readdatavalid | m1_readdatavalid;
      tick();
      s_readdatavalid = 1'b0;
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL m1_read_early_strobe got %b expected 0", early);
      end
      checks++;
      if ({m1_readdatavalid, m0_readdatavalid, m1_readdata} !== {2'b10, 32'h1234_5678}) begin
         errors++;
         $display("FAIL m1_read_data got %b%b %h expected 10 12345678", m1_readdatavalid, m0_readdatavalid, m1_readdata);
      end
      tick();
      checks++;
      if ({m1_readdatavalid, m0_readdatavalid, m1_readdata} !== {2'b00, 32'h1234_5678}) begin
         errors++;
         $display("FAIL m1_read_pulse_hold got %b%b %h expected 00 12345678", m1_readdatavalid, m0_readdatavalid, m1_readdata);
      end
   endtask

   task automatic test_round_robin();
      int          n_cmd;
      int          n_rsp;
      logic        pend;
      logic [17:0] exp_cmd;
      logic [1:0]  exp_pair;
      logic [31:0] got_data;
      n_cmd = 0; n_rsp = 0; pend = 1'b0;
      m0_address = 16'h0100; m1_address = 16'h0200;
      m0_read = 1'b1; m1_read = 1'b1;
      for (int t = 0; t < 12; t++) begin
         tick();
         s_readdatavalid = pend;
         s_readdata = 32'hA000_0000 + 32'(n_cmd - 1);
         pend = 1'b0;
         if (s_read) begin
            checks++;
            exp_cmd = (n_cmd % 2 == 0) ? {16'h0100, 2'b01} : {16'h0200, 2'b10};
            if ({s_address, m0_waitrequest, m1_waitrequest} !== exp_cmd) begin
               errors++;
               $display("FAIL rr_grant_%0d got %h %b%b expected %h %b", n_cmd, s_address, m0_waitrequest, m1_waitrequest, exp_cmd[17:2], exp_cmd[1:0]);
            end
            n_cmd++;
            pend = ~s_waitrequest;
         end
         if (m0_readdatavalid || m1_readdatavalid) begin
            checks++;
            exp_pair = (n_rsp % 2 == 0) ? 2'b10 : 2'b01;
            got_data = (n_rsp % 2 == 0) ? m0_readdata : m1_readdata;
            if ({m0_readdatavalid, m1_readdatavalid} !== exp_pair || got_data !== 32'hA000_0000 + 32'(n_rsp)) begin
               errors++;
               $display("FAIL rr_resp_%0d got %b%b %h expected %b %h", n_rsp, m0_readdatavalid, m1_readdatavalid, got_data, exp_pair, 32'hA000_0000 + 32'(n_rsp));
            end
            n_rsp++;
         end
      end
      m0_read = 1'b0; m1_read = 1'b0; s_readdatavalid = 1'b0;
      checks++;
      if (n_cmd !== 4 || n_rsp !== 4) begin
         errors++;
         $display("FAIL rr_counts got cmd %0d rsp %0d expected 4 4", n_cmd, n_rsp);
      end
   endtask

   task automatic test_timeout();
      logic early;
      early = 1'b0;
      m0_address = 16'h0010; m0_read = 1'b1;
      tick();
      checks++;
      if ({s_read, m0_waitrequest, s_address} !== {2'b10, 16'h0010}) begin
         errors++;
         $display("FAIL to_cmd got %b%b %h expected 10 0010", s_read, m0_waitrequest, s_address);
      end
      tick();
      m0_read = 1'b0;
      early = early | m0_readdatavalid | m1_readdatavalid;
      for (int i = 0; i < 3; i++) begin
         tick();
         early = early | m0_readdatavalid | m1_readdatavalid;
      end
      tick();
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL to_early_strobe got %b expected 0", early);
      end
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b10, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL to_synthetic got %b%b %h expected 10 ffffffff", m0_readdatavalid, m1_readdatavalid, m0_readdata);
      end
      tick();
      tick();
      s_readdatavalid = 1'b1; s_readdata = 32'hDEAD_BEEF;
      tick();
      s_readdatavalid = 1'b0;
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b00, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL to_late_ignored got %b%b %h expected 00 ffffffff", m0_readdatavalid, m1_readdatavalid, m0_readdata);
      end
   endtask

   task automatic test_read_write_collision();
      m0_address = 16'h0020; m0_byteenable = 4'hF; m0_writedata = 32'h0000_0055;
      m0_read = 1'b1; m0_write = 1'b1;
      tick();
      checks++;
      if ({s_read, s_write, s_writedata} !== {2'b01, 32'h0000_0055}) begin
         errors++;
         $display("FAIL rw_write_wins got %b%b %h expected 01 00000055", s_read, s_write, s_writedata);
      end
      tick();
      m0_read = 1'b0; m0_write = 1'b0;
      checks++;
      if ({s_read, s_write, m0_readdatavalid} !== 3'b000) begin
         errors++;
         $display("FAIL rw_done got %b expected 000", {s_read, s_write, m0_readdatavalid});
      end
      m0_address = 16'h0030; m0_read = 1'b1;
      tick();
      tick();
      m0_read = 1'b0;
      tick();
      tick();
      tick();
      s_readdatavalid = 1'b1; s_readdata = 32'hCAFE_F00D;
      tick();
      s_readdatavalid = 1'b0;
      checks++;
      if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL boundary_slave_wins got %b %h expected 1 cafef00d", m0_readdatavalid, m0_readdata);
      end
   endtask

   task automatic test_reset_mid_resp();
      m1_address = 16'h0040; m1_read = 1'b1;
      tick();
      tick();
      m1_read = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin
         errors++;
         $display("FAIL midrst_strobes got %b expected 0011", {s_read, s_write, m0_waitrequest, m1_waitrequest});
      end
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata} !== 66'd0) begin
         errors++;
         $display("FAIL midrst_readdata got %b%b %h %h expected zeros", m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata);
      end
      tick();
      rst_n = 1'b1;
      m0_address = 16'h0070; m0_writedata = 32'h1; m0_write = 1'b1;
      m1_address = 16'h0080; m1_writedata = 32'h2; m1_write = 1'b1;
      tick();
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_write, s_address} !== {3'b011, 16'h0070}) begin
         errors++;
         $display("FAIL midrst_m0_wins got %b %h expected 011 0070", {m0_waitrequest, m1_waitrequest, s_write}, s_address);
      end
      tick();
      m0_write = 1'b0;
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_no_stray_resp got %b expected 00", {m0_readdatavalid, m1_readdatavalid});
      end
      tick();
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_write, s_address, s_writedata} !== {3'b101, 16'h0080, 32'h2}) begin
         errors++;
         $display("FAIL midrst_m1_next got %b %h %h expected 101 0080 00000002", {m0_waitrequest, m1_waitrequest, s_write}, s_address, s_writedata);
      end
      tick();
      m1_write = 1'b0;
   endtask

   initial begin
      test_reset();
      test_m1_read();
      test_round_robin();
      test_timeout();
      test_read_write_collision();
      test_reset_mid_resp();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
